mario_motion_ctrl: RTL

- Per-frame motion sequencer for the Mario sprite. Samples keycode and the current sprite position once per frame tick.
- Runs the ground/jump/fall state machine, including gravity ramp, jump buffering and screen-edge clamping.
- Emits one signed (dx, dy) step per frame for the position register to accumulate. It is the only source of motion commands for the player sprite.

---
 rtl/mario_pkg.sv | 16 +
 rtl/mario_motion_ctrl_fall_accel.sv | 31 +++
 rtl/mario_motion_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mario_pkg.sv
// mario_pkg: shared motion types, keycodes, screen limits and step clamp helper
package mario_pkg;
   typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, APEX = 2'd2, FALL = 2'd3} motion_state_t;
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_W = 8'h1A;
   localparam int SCREEN_X_MIN = 15;
   localparam int SCREEN_X_MAX = 622;
   localparam int SCREEN_Y_CEIL = 1;
   localparam int SCREEN_Y_FLOOR = 396;
   // min(lim, room), with no room (zero or negative) giving a zero step
   function automatic logic [9:0] step_mag(input logic signed [10:0] room, input logic [9:0] lim);
      return (room[10] || room == '0) ? 10'd0 : (room[9:0] < lim) ? room[9:0] : lim;
   endfunction
endpackage

// File: rtl/mario_motion_ctrl_fall_accel.sv
// fall_accel: saturating fall-speed ramp for the FALL state
//   Clk, Reset : clock and synchronous active-high reset
//   clear      : restart the ramp (speed=1, frame counter=0)
//   tick       : one FALL frame elapsed
//   boost      : jump straight to the terminal speed
//   speed      : current fall speed in pixels per frame
module fall_accel #(
   parameter int FALL_MAX = 4,
   parameter int ACCEL_FRAMES = 8
)(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       clear,
   input  logic       tick,
   input  logic       boost,
   output logic [2:0] speed
);
   localparam int CW = $clog2(ACCEL_FRAMES);
   logic [CW-1:0] accel_cnt;
   logic          wrap;
   assign wrap = accel_cnt == CW'(ACCEL_FRAMES - 1);
   always_ff @(posedge Clk) begin
      if (Reset || clear) begin
         speed     <= 3'd1;
         accel_cnt <= '0;
      end else if (tick) begin
         accel_cnt <= wrap ? '0 : accel_cnt + 1'b1;
         speed     <= boost ? 3'(FALL_MAX) : (wrap && speed < 3'(FALL_MAX)) ? speed + 3'd1 : speed;
      end
   end
endmodule

// File: rtl/mario_motion_ctrl.sv
// mario_motion_ctrl: per-frame ground/jump/fall sequencer emitting one (dx, dy) step per frame
//   Clk, Reset  : clock and synchronous active-high reset
//   frame_tick  : one-cycle pulse per video frame; all evaluation happens here
//   keycode     : USB keycode (A/D walk, W jump, S fast fall)
//   pos_x/pos_y : current sprite top-left position
//   dx/dy       : signed step, held until the next strobe (dy positive = down)
//   move_valid  : one-cycle strobe, one Clk after frame_tick
//   state       : GROUND=0, RISE=1, APEX=2, FALL=3
//   on_ground   : registered pos_y >= Y_FLOOR
module mario_motion_ctrl
   import mario_pkg::*;
#(
   parameter int WALK_SPEED   = 2,
   parameter int RISE_SPEED   = 2,
   parameter int JUMP_FRAMES  = 63,
   parameter int APEX_FRAMES  = 4,
   parameter int FALL_MAX     = 4,
   parameter int ACCEL_FRAMES = 8,
   parameter int BUF_FRAMES   = 4,
   parameter int X_MIN        = SCREEN_X_MIN,
   parameter int X_MAX        = SCREEN_X_MAX,
   parameter int Y_CEIL       = SCREEN_Y_CEIL,
   parameter int Y_FLOOR      = SCREEN_Y_FLOOR
)(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   input  logic [9:0] pos_x,
   input  logic [9:0] pos_y,
   output logic [9:0] dx,
   output logic [9:0] dy,
   output logic       move_valid,
   output logic [1:0] state,
   output logic       on_ground
);
   localparam int RW = $clog2(JUMP_FRAMES + 1);
   localparam int AW = $clog2(APEX_FRAMES + 1);
   localparam int BW = $clog2(BUF_FRAMES + 1);
   motion_state_t      cur_state, nxt_state;
   logic [RW-1:0]      rise_cnt, nxt_rise;
   logic [AW-1:0]      apex_cnt, nxt_apex;
   logic [BW-1:0]      buf_cnt, nxt_buf_cnt;
   logic               jump_buf, nxt_buf;
   logic [9:0]         nxt_dx, nxt_dy;
   logic [2:0]         speed;
   logic               key_w;
   logic signed [10:0] room_l, room_r, room_up, room_dn;
   // 11-bit distances to each screen limit; negative means already past it
   assign room_l  = {1'b0, pos_x} - 11'(X_MIN);
   assign room_r  = 11'(X_MAX) - {1'b0, pos_x};
   assign room_up = {1'b0, pos_y} - 11'(Y_CEIL);
   assign room_dn = 11'(Y_FLOOR) - {1'b0, pos_y};
   assign key_w   = keycode == KEY_W;
   assign state   = cur_state;
   fall_accel #(.FALL_MAX(FALL_MAX), .ACCEL_FRAMES(ACCEL_FRAMES)) u_fall_accel (
      .Clk   (Clk),
      .Reset (Reset),
      .clear (frame_tick && cur_state != FALL),
      .tick  (frame_tick && cur_state == FALL),
      .boost (keycode == KEY_S),
      .speed (speed)
   );
   always_comb begin
      nxt_state   = cur_state;
      nxt_dy      = '0;
      nxt_rise    = rise_cnt;
      nxt_apex    = apex_cnt;
      nxt_buf     = jump_buf;
      nxt_buf_cnt = buf_cnt;
      nxt_dx      = keycode == KEY_A ? -step_mag(room_l, 10'(WALK_SPEED)) :
                    keycode == KEY_D ?  step_mag(room_r, 10'(WALK_SPEED)) : '0;
      // buffered jump ages out one frame at a time; W while airborne refreshes it
      if (jump_buf) begin
         nxt_buf_cnt = buf_cnt - 1'b1;
         nxt_buf     = buf_cnt > BW'(1);
      end
      if (key_w && cur_state != GROUND) begin
         nxt_buf     = 1'b1;
         nxt_buf_cnt = BW'(BUF_FRAMES);
      end
      case (cur_state)
         GROUND: begin
            if (key_w || jump_buf) begin
               nxt_state   = RISE;
               nxt_rise    = RW'(JUMP_FRAMES);
               nxt_buf     = 1'b0;
               nxt_buf_cnt = '0;
            end else if (pos_y < 10'(Y_FLOOR))
               nxt_state = FALL;
         end
         RISE: begin
            nxt_dy   = -step_mag(room_up, 10'(RISE_SPEED));
            nxt_rise = rise_cnt - 1'b1;
            // end of rise: counter exhausted, ceiling reached, or W released after the minimum rise
            if (rise_cnt <= RW'(1) || room_up <= 11'(RISE_SPEED) || (!key_w && rise_cnt < RW'(JUMP_FRAMES - 8))) begin
               nxt_state = APEX;
               nxt_apex  = AW'(APEX_FRAMES);
            end
         end
         APEX: begin
            nxt_apex = apex_cnt - 1'b1;
            if (apex_cnt <= AW'(1))
               nxt_state = FALL;
         end
         FALL: begin
            nxt_dy = step_mag(room_dn, {7'd0, speed});
            if (room_dn <= $signed({8'd0, speed}))
               nxt_state = GROUND;
         end
         default: nxt_state = FALL;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cur_state  <= FALL;
         dx         <= '0;
         dy         <= '0;
         move_valid <= 1'b0;
         on_ground  <= 1'b0;
         rise_cnt   <= '0;
         apex_cnt   <= '0;
         buf_cnt    <= '0;
         jump_buf   <= 1'b0;
      end else begin
         move_valid <= frame_tick;
         if (frame_tick) begin
            cur_state <= nxt_state;
            dx        <= nxt_dx;
            dy        <= nxt_dy;
            on_ground <= pos_y >= 10'(Y_FLOOR);
            rise_cnt  <= nxt_rise;
            apex_cnt  <= nxt_apex;
            buf_cnt   <= nxt_buf_cnt;
            jump_buf  <= nxt_buf;
         end
      end
   end
endmodule
